// File: rtl/rs_decoder_job_ctrl_if.sv
// Host-side bus of the RS decoder job controller: MMIO write channel from
// the CCI-P decode plus the DSM completion-record handshake.
interface rs_decoder_job_ctrl_if;
    logic        mmio_wr_valid;
    logic [15:0] mmio_wr_addr;
    logic [63:0] mmio_wr_data;
    logic        dsm_wr_req;
    logic [63:0] dsm_wr_data;
    logic        dsm_wr_ack;

    modport master (
        output mmio_wr_valid,
        output mmio_wr_addr,
        output mmio_wr_data,
        output dsm_wr_ack,
        input  dsm_wr_req,
        input  dsm_wr_data
    );

    modport slave (
        input  mmio_wr_valid,
        input  mmio_wr_addr,
        input  mmio_wr_data,
        input  dsm_wr_ack,
        output dsm_wr_req,
        output dsm_wr_data
    );
endinterface

// File: rtl/rs_decoder_job_ctrl.sv
// MMIO-programmed job controller for the Reed-Solomon decoder AFU: holds the
// descriptor table, sequences the rd/wr engines and posts a DSM completion record.
module rs_decoder_job_ctrl #(
    parameter int unsigned NUM_BUFFERS   = 2,
    parameter logic [15:0] BUF_BASE_BYTE = 16'h120,
    parameter logic [15:0] DSM_BYTE      = 16'h110,
    parameter logic [15:0] CTRL_BYTE     = 16'h118
) (
    input  logic                      clk,
    input  logic                      reset_n,
    rs_decoder_job_ctrl_if.slave      host,
    output logic [64*NUM_BUFFERS-1:0] buf_addr,
    output logic [32*NUM_BUFFERS-1:0] buf_size,
    output logic [63:0]               dsm_base,
    output logic                      eng_rst,
    output logic                      rd_start,
    output logic                      wr_start,
    output logic                      eng_abort,
    input  logic                      rd_done,
    input  logic                      wr_done,
    output logic                      busy,
    output logic [31:0]               job_count,
    output logic                      err_oob,
    output logic                      err_busy_wr
);

    localparam logic [15:0] DSM_WORD  = DSM_BYTE >> 2;
    localparam logic [15:0] CTRL_WORD = CTRL_BYTE >> 2;
    localparam logic [15:0] BUF_WORD  = BUF_BASE_BYTE >> 2;
    localparam logic [15:0] NUM_BUF_W = 16'(NUM_BUFFERS);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_ABORT,
        S_DSM
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rd_seen;
    logic        wr_seen;
    logic        rd_seen_nxt;
    logic        wr_seen_nxt;
    logic        job_done;

    logic        word_ok;
    logic        dsm_hit;
    logic        ctrl_hit;
    logic        buf_hit;
    logic        buf_oob;
    logic [15:0] buf_idx;
    logic [31:0] cmd;
    logic        cmd_assert;
    logic        cmd_deassert;
    logic        cmd_start;
    logic        cmd_stop;

    logic [63:0] addr_q [NUM_BUFFERS];
    logic [31:0] size_q [NUM_BUFFERS];

    // Only even word addresses below 0x100 decode; odd halves of 64-bit CSRs are ignored.
    always_comb begin
        word_ok  = host.mmio_wr_valid && (host.mmio_wr_addr < 16'h100) && !host.mmio_wr_addr[0];
        dsm_hit  = word_ok && (host.mmio_wr_addr == DSM_WORD);
        ctrl_hit = word_ok && (host.mmio_wr_addr == CTRL_WORD);
        buf_hit  = word_ok && (host.mmio_wr_addr >= BUF_WORD) && !dsm_hit && !ctrl_hit;
        buf_idx  = (host.mmio_wr_addr - BUF_WORD) >> 2;
        buf_oob  = buf_hit && (buf_idx >= NUM_BUF_W);
        cmd      = host.mmio_wr_data[31:0];
    end

    assign cmd_assert   = ctrl_hit && (cmd == 32'd0);
    assign cmd_deassert = ctrl_hit && (cmd == 32'd1);
    assign cmd_start    = ctrl_hit && (cmd == 32'd3);
    assign cmd_stop     = ctrl_hit && (cmd == 32'd7);

    // Done pulses are captured from LAUNCH onward so an engine finishing instantly is not lost.
    always_comb begin
        state_nxt   = state;
        rd_seen_nxt = rd_seen;
        wr_seen_nxt = wr_seen;
        job_done    = 1'b0;
        case (state)
            S_RESET: begin
                if (cmd_deassert) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (cmd_start) begin
                    state_nxt   = S_LAUNCH;
                    rd_seen_nxt = 1'b0;
                    wr_seen_nxt = 1'b0;
                end
            end
            S_LAUNCH: begin
                rd_seen_nxt = rd_seen | rd_done;
                wr_seen_nxt = wr_seen | wr_done;
                state_nxt   = S_BUSY;
            end
            S_BUSY: begin
                rd_seen_nxt = rd_seen | rd_done;
                wr_seen_nxt = wr_seen | wr_done;
                if (rd_seen_nxt && wr_seen_nxt) state_nxt = S_DSM;
                else if (cmd_stop)              state_nxt = S_ABORT;
            end
            S_ABORT: begin
                rd_seen_nxt = rd_seen | rd_done;
                wr_seen_nxt = wr_seen | wr_done;
                if (rd_seen_nxt && wr_seen_nxt) state_nxt = S_IDLE;
            end
            S_DSM: begin
                if (host.dsm_wr_ack) begin
                    state_nxt = S_IDLE;
                    job_done  = 1'b1;
                end
            end
            default: state_nxt = S_RESET;
        endcase
        if (cmd_assert) begin
            state_nxt   = S_RESET;
            rd_seen_nxt = 1'b0;
            wr_seen_nxt = 1'b0;
            job_done    = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_RESET;
            rd_seen         <= 1'b0;
            wr_seen         <= 1'b0;
            eng_rst         <= 1'b1;
            rd_start        <= 1'b0;
            wr_start        <= 1'b0;
            eng_abort       <= 1'b0;
            busy            <= 1'b0;
            host.dsm_wr_req <= 1'b0;
            job_count       <= 32'd0;
        end else begin
            state           <= state_nxt;
            rd_seen         <= rd_seen_nxt;
            wr_seen         <= wr_seen_nxt;
            eng_rst         <= (state_nxt == S_RESET);
            rd_start        <= (state_nxt == S_LAUNCH);
            wr_start        <= (state_nxt == S_LAUNCH);
            eng_abort       <= (state_nxt == S_ABORT);
            busy            <= (state_nxt == S_LAUNCH) || (state_nxt == S_BUSY) ||
                               (state_nxt == S_ABORT)  || (state_nxt == S_DSM);
            host.dsm_wr_req <= (state_nxt == S_DSM);
            if (job_done) job_count <= job_count + 32'd1;
        end
    end

    // Out-of-range descriptor writes take precedence over the busy check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
                addr_q[i] <= 64'd0;
                size_q[i] <= 32'd0;
            end
            dsm_base    <= 64'd0;
            err_oob     <= 1'b0;
            err_busy_wr <= 1'b0;
        end else begin
            if (buf_oob) begin
                err_oob <= 1'b1;
            end else if ((buf_hit || dsm_hit) && busy) begin
                err_busy_wr <= 1'b1;
            end else if (dsm_hit) begin
                dsm_base <= host.mmio_wr_data;
            end else if (buf_hit) begin
                for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
                    if (buf_idx == 16'(i)) begin
                        if (host.mmio_wr_addr[1]) size_q[i] <= host.mmio_wr_data[31:0];
                        else                      addr_q[i] <= host.mmio_wr_data;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_BUFFERS); g++) begin : g_pack
        assign buf_addr[64*g +: 64] = addr_q[g];
        assign buf_size[32*g +: 32] = size_q[g];
    end

    assign host.dsm_wr_data = {32'h1, job_count};

endmodule

// File: doc/rs_decoder_job_ctrl.md
Name: rs_decoder_job_ctrl

Overview:
- MMIO-programmed job controller for the Reed-Solomon decoder AFU.
- Captures host CSR writes for the DSM base, the control word and a bounds-checked table of buffer descriptors (address/size pairs).
- Holds the read/write engines in soft reset, launches them, tracks completion, aborts on STOP and posts a completion record to DSM.
- Sits between the CCI-P MMIO decode and the rd/wr request engines.

Parameters:
NUM_BUFFERS, 2, number of buffer descriptors; index range 0..NUM_BUFFERS-1
BUF_BASE_BYTE, 16'h120, byte address of descriptor 0; descriptor i address at BUF_BASE_BYTE+16*i, size at +8
DSM_BYTE, 16'h110, byte address of DSM base CSR
CTRL_BYTE, 16'h118, byte address of control CSR

Ports:
clk  in  1  AFU clock
reset_n  in  1  asynchronous active-low reset
mmio_wr_valid  in  1  MMIO write strobe, one cycle
mmio_wr_addr  in  16  CCI-P MMIO address in 32-bit word units (byte>>2)
mmio_wr_data  in  64  write data
buf_addr  out  64*NUM_BUFFERS  descriptor addresses, index i at [64i+:64]
buf_size  out  32*NUM_BUFFERS  descriptor sizes (mmio_wr_data[31:0])
dsm_base  out  64  DSM base address
eng_rst  out  1  soft reset to rd/wr engines
rd_start  out  1  one-cycle launch pulse to read engine
wr_start  out  1  one-cycle launch pulse to write engine
eng_abort  out  1  level; requests engines to terminate
rd_done  in  1  read engine completion pulse
wr_done  in  1  write engine completion pulse
dsm_wr_req  out  1  request to post completion record
dsm_wr_data  out  64  {32'h1, job_count}
dsm_wr_ack  in  1  DSM write accepted
busy  out  1  high in LAUNCH, BUSY, ABORT, DSM
job_count  out  32  completed (non-aborted) jobs, wraps at 2^32
err_oob  out  1  sticky: write to descriptor index >= NUM_BUFFERS
err_busy_wr  out  1  sticky: descriptor/DSM write while busy

Behaviour:
- Reset: all registers and outputs 0 except eng_rst=1; state S_RESET.
- Decode, word address A = mmio_wr_addr, valid only when A < 16'h100:
  - A == DSM_BYTE>>2: write dsm_base.
  - A == CTRL_BYTE>>2: control command.
  - A >= BUF_BASE_BYTE>>2: i = (A - (BUF_BASE_BYTE>>2))>>2, field = A[1] (0 = addr, 1 = size).
  - Odd word addresses are ignored.
- Descriptor bounds:
  - i compared at full 16-bit width against NUM_BUFFERS.
  - i >= NUM_BUFFERS: write dropped, err_oob set; no other register changes.
- Config writes (descriptor, DSM) while busy=1: dropped, err_busy_wr set.
- Accepted writes are visible on outputs the cycle after mmio_wr_valid.
- Commands use mmio_wr_data[31:0]: 0 = ASSERT_RST, 1 = DEASSERT_RST, 3 = START, 7 = STOP. Other values are ignored.
- States:
  - S_RESET: eng_rst=1. DEASSERT_RST -> S_IDLE. START/STOP ignored.
  - S_IDLE: eng_rst=0. START -> S_LAUNCH. STOP ignored.
  - S_LAUNCH: rd_start=wr_start=1 for exactly this cycle; clear rd_seen/wr_seen -> S_BUSY.
  - S_BUSY: rd_done sets rd_seen, wr_done sets wr_seen; a pulse arriving in S_LAUNCH is also captured. When both seen (including the same cycle) -> S_DSM. STOP -> S_ABORT.
  - S_ABORT: eng_abort=1; continue capturing done pulses; when both seen -> S_IDLE. No DSM write, job_count unchanged.
  - S_DSM: dsm_wr_req=1 held until dsm_wr_ack. On ack: job_count+1, -> S_IDLE. dsm_wr_data is stable while req is high.
- START outside S_IDLE is ignored.
- ASSERT_RST in any state: next state S_RESET, eng_rst=1 next cycle. Clears rd_seen/wr_seen, dsm_wr_req and eng_abort. Descriptors, dsm_base, job_count and error flags are retained.
- Latency: START write at cycle T -> rd_start/wr_start high at T+1 -> busy at T+1.
- reset_n assertion mid-job: everything returns immediately to reset values.

Test Plan:
- Reset, write DEASSERT_RST (word 0x46, data 1) -> eng_rst 1→0 next cycle, busy=0.
- Write word 0x48 = 0x1000, 0x4A = 64, 0x4C = 0x2000, 0x4E = 128 -> buf_addr[0]=0x1000, buf_size[0]=64, buf_addr[1]=0x2000, buf_size[1]=128; err_oob=0.
- Write word 0x50 (index 2) = 0xDEAD -> err_oob=1, buf_addr[0]/[1] unchanged.
- START at T -> rd_start/wr_start high only at T+1; rd_done and wr_done in the same cycle -> dsm_wr_req high; ack after 3 cycles -> job_count=1, dsm_wr_data=0x0000_0001_0000_0000 during req, busy=0.
- START, then STOP after rd_done only -> eng_abort=1 until wr_done; return to idle; no dsm_wr_req; job_count unchanged; START accepted afterwards.
- START, write word 0x48 while busy -> dropped, err_busy_wr=1. ASSERT_RST mid-job -> eng_rst=1 next cycle, busy=0; START then ignored until DEASSERT_RST.
